// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types and widths for the UART transmit scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_SEND  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin arbiter; the first request at or above
//            the pointer wins, wrapping to the lowest request otherwise.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0] gnt_id_o,
  output logic             any_o
);

  logic [N_REQ-1:0] w_mask;
  logic [N_REQ-1:0] w_req_hi;
  logic [N_REQ-1:0] w_pick_src;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
    assign w_mask[gi] = (ptr_i <= PTR_W'(gi));
  end

  assign w_req_hi   = req_i & w_mask;
  assign w_pick_src = (|w_req_hi) ? w_req_hi : req_i;
  // Isolate the lowest set bit of the chosen request vector.
  assign gnt_o      = w_pick_src & (~w_pick_src + N_REQ'(1));
  assign any_o      = |req_i;

  always_comb begin
    gnt_id_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_o[i]) begin
        gnt_id_o = gnt_id_o | PTR_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler
// Purpose  : Round-robin scheduler feeding bytes from N_REQ requesters into a
//            single UART transmitter with start/ack handshake and idle gap.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int GAP_CYC = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       tx_ready,
  output logic                       tx_start,
  output logic [DATA_W-1:0]          tx_data,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic [FRAME_CNT_W-1:0]     frame_cnt
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;

  state_e                  state_q,     state_d;
  logic                    tx_start_q,  tx_start_d;
  logic [DATA_W-1:0]       tx_data_q,   tx_data_d;
  logic [ID_W-1:0]         grant_id_q,  grant_id_d;
  logic [ID_W-1:0]         rr_ptr_q,    rr_ptr_d;
  logic [FRAME_CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [GAP_W-1:0]        gap_q,       gap_d;

  logic [N_REQ-1:0]        w_gnt;
  logic [ID_W-1:0]         w_win_id;
  logic                    w_any;
  logic [DATA_W-1:0]       w_win_data;
  logic [ID_W-1:0]         w_next_ptr;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (ID_W)
  ) u_arb (
    .req_i    (req_valid),
    .ptr_i    (rr_ptr_q),
    .gnt_o    (w_gnt),
    .gnt_id_o (w_win_id),
    .any_o    (w_any)
  );

  always_comb begin
    w_win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) begin
        w_win_data = w_win_data | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_next_ptr = (w_win_id == ID_W'(N_REQ - 1)) ? '0 : w_win_id + ID_W'(1);

  always_comb begin
    state_d     = state_q;
    tx_start_d  = tx_start_q;
    tx_data_d   = tx_data_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    frame_cnt_d = frame_cnt_q;
    gap_d       = gap_q;
    req_ready   = '0;

    case (state_q)
      ST_IDLE: begin
        // rst_n gates the combinational accept so nothing is offered during reset.
        if (rst_n && tx_ready && w_any) begin
          req_ready  = w_gnt;
          tx_data_d  = w_win_data;
          grant_id_d = w_win_id;
          rr_ptr_d   = w_next_ptr;
          tx_start_d = 1'b1;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (!tx_ready) begin
          tx_start_d = 1'b0;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
          if (GAP_CYC > 0) begin
            gap_d   = GAP_LOAD;
            state_d = ST_GAP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      frame_cnt_q <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      frame_cnt_q <= frame_cnt_d;
      gap_q       <= gap_d;
    end
  end

  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign grant_id  = grant_id_q;
  assign busy      = (state_q != ST_IDLE);
  assign frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_scheduler
// Purpose  : Self-checking bench for uart_tx_scheduler with a transmitter model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_scheduler;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int GAP1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            tx_ready, tx_start, busy;
  logic [DW-1:0]   tx_data;
  logic [1:0]      grant_id;
  logic [15:0]     frame_cnt;

  logic [N-1:0]    req_valid1;
  logic [N*DW-1:0] req_data1;
  logic [N-1:0]    req_ready1;
  logic            tx_ready1, tx_start1, busy1;
  logic [DW-1:0]   tx_data1;
  logic [1:0]      grant_id1;
  logic [15:0]     frame_cnt1;

  uart_tx_scheduler #(.N_REQ(N), .DATA_W(DW), .GAP_CYC(0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_ready(tx_ready), .tx_start(tx_start),
    .tx_data(tx_data), .grant_id(grant_id), .busy(busy), .frame_cnt(frame_cnt)
  );

  uart_tx_scheduler #(.N_REQ(N), .DATA_W(DW), .GAP_CYC(GAP1)) dut_gap (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_data(req_data1),
    .req_ready(req_ready1), .tx_ready(tx_ready1), .tx_start(tx_start1),
    .tx_data(tx_data1), .grant_id(grant_id1), .busy(busy1), .frame_cnt(frame_cnt1)
  );

  // Transmitter model: drops ready two cycles after tx_start, stays low tx_len cycles.
  logic m_ready;
  int   m_phase;
  int   m_cnt;
  int   tx_len;
  logic force_low;
  assign tx_ready = m_ready & ~force_low;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready <= 1'b1;
      m_phase <= 0;
      m_cnt   <= 0;
    end else begin
      case (m_phase)
        0: if (tx_start) m_phase <= 1;
        1: begin m_ready <= 1'b0; m_cnt <= tx_len; m_phase <= 2; end
        default: begin
          if (m_cnt <= 1) begin m_ready <= 1'b1; m_phase <= 0; end
          else m_cnt <= m_cnt - 1;
        end
      endcase
    end
  end

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: pending set, pointer, frame in flight, frame total.
  logic        mdl_busy   = 1'b0;
  logic        mdl_low    = 1'b0;
  int          mdl_ptr    = 0;
  logic [15:0] mdl_frames = '0;
  logic [DW-1:0] mdl_data = '0;
  int          mdl_id     = 0;

  function automatic int rr_winner(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic monitor_step();
    logic [N-1:0] exp_rdy;
    int w;
    if (!rst_n) begin
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_tx_start", {31'd0, tx_start}, 0);
      chk("rst_req_ready", {28'd0, req_ready}, 0);
      chk("rst_frame_cnt", {16'd0, frame_cnt}, 0);
      chk("rst_tx_data", {24'd0, tx_data}, 0);
      chk("rst_grant_id", {30'd0, grant_id}, 0);
      mdl_busy = 1'b0; mdl_low = 1'b0; mdl_ptr = 0; mdl_frames = '0;
      return;
    end
    w = rr_winner(req_valid, mdl_ptr);
    exp_rdy = '0;
    if (!mdl_busy && tx_ready && w >= 0) exp_rdy[w] = 1'b1;
    chk("mon_busy", {31'd0, busy}, {31'd0, mdl_busy});
    chk("mon_tx_start", {31'd0, tx_start}, {31'd0, mdl_busy & ~mdl_low});
    chk("mon_req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
    chk("mon_frame_cnt", {16'd0, frame_cnt}, {16'd0, mdl_frames});
    if (mdl_busy) begin
      chk("mon_tx_data", {24'd0, tx_data}, {24'd0, mdl_data});
      chk("mon_grant_id", {30'd0, grant_id}, mdl_id);
    end
    if (exp_rdy != '0) begin
      mdl_busy = 1'b1;
      mdl_low  = 1'b0;
      mdl_id   = w;
      mdl_data = req_data[w*DW +: DW];
      mdl_ptr  = (w + 1) % N;
    end else if (mdl_busy) begin
      if (!tx_ready) mdl_low = 1'b1;
      else if (mdl_low) begin
        mdl_frames = mdl_frames + 16'd1;
        mdl_busy   = 1'b0;
      end
    end
  endtask

  always @(negedge clk) monitor_step();

  // One cycle of requester behaviour: withdraw whatever was accepted at the edge.
  task automatic tick(output logic [N-1:0] acc);
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, {31'd0, busy}, 0);
  endtask

  typedef struct packed {
    logic            do_rst;
    logic [N-1:0]    mask;
    logic [N*DW-1:0] data;
    logic [11:0]     len;
    logic [2:0]      n_exp;
    logic [7:0]      exp_ids;
    logic [15:0]     exp_frames;
  } vec_t;

  vec_t         tbl [6];
  vec_t         v;
  logic [N-1:0] acc;
  logic [N-1:0] one_hot;
  logic [1:0]   exp_id;
  int           got, cyc, stalled, n, gap, starts;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b1;
    force_low  = 1'b0;
    tx_len     = 4;
    req_valid  = '0;
    req_data   = '0;
    req_valid1 = '0;
    req_data1  = '0;
    tx_ready1  = 1'b1;

    tbl[0] = '{1'b1, 4'h1, 32'h000000A5, 12'd1760, 3'd1, 8'h00, 16'd1};
    tbl[1] = '{1'b1, 4'hF, 32'h44332211, 12'd10,   3'd4, 8'hE4, 16'd4};
    tbl[2] = '{1'b1, 4'h2, 32'h0000B700, 12'd5,    3'd1, 8'h01, 16'd1};
    tbl[3] = '{1'b0, 4'hA, 32'hD400C200, 12'd6,    3'd2, 8'h07, 16'd3};
    tbl[4] = '{1'b0, 4'h5, 32'h00E300F0, 12'd3,    3'd2, 8'h02, 16'd5};
    tbl[5] = '{1'b0, 4'hF, 32'h5A3C1E0F, 12'd2,    3'd4, 8'h39, 16'd9};

    for (int r = 0; r < 6; r++) begin
      v = tbl[r];
      if (v.do_rst) do_reset();
      tx_len    = int'(v.len);
      req_data  = v.data;
      req_valid = v.mask;
      got = 0;
      cyc = 0;
      while ((got < int'(v.n_exp) || busy) && cyc < 20000) begin
        tick(acc);
        cyc++;
        if (acc != '0) begin
          if (got < int'(v.n_exp)) begin
            exp_id  = v.exp_ids[got*2 +: 2];
            one_hot = '0;
            one_hot[exp_id] = 1'b1;
            chk("tbl_grant", {28'd0, acc}, {28'd0, one_hot});
            chk("tbl_tx_data", {24'd0, tx_data}, {24'd0, v.data[exp_id*DW +: DW]});
            chk("tbl_grant_id", {30'd0, grant_id}, {30'd0, exp_id});
            chk("tbl_tx_start", {31'd0, tx_start}, 1);
          end
          got++;
        end
      end
      chk("tbl_served", got, int'(v.n_exp));
      chk("tbl_frame_cnt", {16'd0, frame_cnt}, {16'd0, v.exp_frames});
      chk("tbl_idle", {31'd0, busy}, 0);
    end

    // Transmitter held busy: requests wait, grant follows as soon as it frees.
    force_low = 1'b1;
    tx_len    = 4;
    req_data  = 32'h00000077;
    req_valid = 4'h1;
    stalled   = 0;
    for (int i = 0; i < 50; i++) begin
      tick(acc);
      if (acc != '0) stalled++;
    end
    chk("hold_no_grant", stalled, 0);
    force_low = 1'b0;
    @(negedge clk);
    chk("hold_release_ready", {28'd0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    req_valid = '0;
    chk("hold_tx_start", {31'd0, tx_start}, 1);
    chk("hold_tx_data", {24'd0, tx_data}, 32'h77);
    wait_idle("hold_drain");
    chk("hold_frame_cnt", {16'd0, frame_cnt}, 10);

    // Reset while a frame is on the wire.
    tx_len    = 40;
    req_data  = 32'h00003300;
    req_valid = 4'h2;
    n = 0;
    while (!(busy && !tx_start) && n < 100) begin
      tick(acc);
      n++;
    end
    chk("rst_reached_send", {31'd0, busy & ~tx_start}, 1);
    #2;
    rst_n     = 1'b0;
    req_valid = 4'hF;
    #1;
    chk("rst_async_tx_start", {31'd0, tx_start}, 0);
    chk("rst_async_busy", {31'd0, busy}, 0);
    chk("rst_async_frame_cnt", {16'd0, frame_cnt}, 0);
    repeat (3) @(posedge clk);
    #1;
    req_valid = '0;
    rst_n     = 1'b1;
    starts    = 0;
    for (int i = 0; i < 20; i++) begin
      tick(acc);
      if (tx_start) starts++;
    end
    chk("rst_no_relaunch", starts, 0);
    chk("rst_frame_cnt_after", {16'd0, frame_cnt}, 0);

    // Randomised traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      tx_len = $urandom_range(1, 8);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
          req_data[i*DW +: DW] = 8'($urandom);
        end
      end
      if ($urandom_range(0, 49) == 0) force_low = ~force_low;
      tick(acc);
    end
    force_low = 1'b0;
    n = 0;
    while ((req_valid != '0 || busy) && n < 5000) begin
      tick(acc);
      n++;
    end
    chk("rand_drained", {28'd0, req_valid}, 0);
    wait_idle("rand_idle");

    // Idle gap on the GAP_CYC=3 instance.
    req_data1  = 32'h0000BBAA;
    req_valid1 = 4'h1;
    tx_ready1  = 1'b1;
    @(negedge clk);
    chk("gap_first_ready", {28'd0, req_ready1}, 32'h1);
    @(posedge clk);
    #1;
    req_valid1 = 4'h2;
    chk("gap_first_data", {24'd0, tx_data1}, 32'hAA);
    @(posedge clk);
    #1;
    tx_ready1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tx_ready1 = 1'b1;
    n = 0;
    while (frame_cnt1 == 16'd0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("gap_frame_done", {16'd0, frame_cnt1}, 1);
    gap = 0;
    while (busy1 && req_ready1 == '0 && gap < 10) begin
      gap++;
      @(negedge clk);
    end
    chk("gap_cycles", gap, GAP1);
    chk("gap_next_grant", {28'd0, req_ready1}, 32'h2);
    @(posedge clk);
    #1;
    req_valid1 = '0;
    chk("gap_second_data", {24'd0, tx_data1}, 32'hBB);
    chk("gap_second_id", {30'd0, grant_id1}, 1);
    chk("gap_second_start", {31'd0, tx_start1}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
